// File: rtl/thunderbird_seq.sv
// Two-sided tail-light sequencer: left/right turn sweeps, hazard flash and brake overlay,
// with a programmable step-rate prescaler.
module thunderbird_seq #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] tick_div,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  input  logic             brake,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic             busy
);

  localparam int unsigned PhW = $clog2(LAMPS + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLeft   = 2'd1;
  localparam logic [1:0] StRight  = 2'd2;
  localparam logic [1:0] StHazard = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [LAMPS-1:0] left_q, left_d;
  logic [LAMPS-1:0] right_q, right_d;
  logic             busy_q, busy_d;

  logic             step;
  logic             both_req;
  logic [LAMPS:0]   seq_ext;
  logic [LAMPS-1:0] seq_pat;

  assign both_req = left_req & right_req;
  assign step     = (state_q != StIdle) && (presc_q == tick_div);

  // Thermometer fill: phase 0 = all off, phase LAMPS = all on.
  assign seq_ext = ({{LAMPS{1'b0}}, 1'b1} << phase_q) - {{LAMPS{1'b0}}, 1'b1};
  assign seq_pat = seq_ext[LAMPS-1:0];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    presc_d = presc_q;

    if ((hazard_req || (both_req && state_q == StIdle)) && state_q != StHazard) begin
      state_d = StHazard;
    end else begin
      case (state_q)
        StIdle: begin
          if (left_req) begin
            state_d = StLeft;
          end else if (right_req) begin
            state_d = StRight;
          end
        end
        StLeft:   if (!left_req) state_d = StIdle;
        StRight:  if (!right_req) state_d = StIdle;
        default:  if (!(hazard_req || both_req)) state_d = StIdle;
      endcase
    end

    if (state_d != state_q) begin
      phase_d = '0;
      presc_d = '0;
    end else if (state_q != StIdle) begin
      if (step) begin
        presc_d = '0;
        if (state_q == StHazard) begin
          phase_d = (phase_q == '0) ? PhW'(1) : '0;
        end else begin
          phase_d = (phase_q == PhW'(LAMPS)) ? '0 : phase_q + PhW'(1);
        end
      end else begin
        // A count above a freshly lowered tick_div runs on and wraps naturally.
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    left_d  = '0;
    right_d = '0;
    case (state_q)
      StIdle: begin
        if (brake) begin
          left_d  = '1;
          right_d = '1;
        end
      end
      StLeft: begin
        left_d = seq_pat;
        if (brake) right_d = '1;
      end
      StRight: begin
        right_d = seq_pat;
        if (brake) left_d = '1;
      end
      default: begin
        if (phase_q != '0) begin
          left_d  = '1;
          right_d = '1;
        end
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      presc_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      left_q  <= left_d;
      right_q <= right_d;
      busy_q  <= busy_d;
    end
  end

  assign left_lamps  = left_q;
  assign right_lamps = right_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench for thunderbird_seq: directed scenarios then randomized stimulus, checked
// against a mode/phase reference model.
module tb_thunderbird_seq;

  localparam int LAMPS = 3;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] tick_div;
  logic             left_req, right_req, hazard_req, brake;
  logic [LAMPS-1:0] left_lamps, right_lamps;
  logic             busy;

  thunderbird_seq #(.LAMPS(LAMPS), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_div   (tick_div),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .brake      (brake),
    .left_lamps (left_lamps),
    .right_lamps(right_lamps),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LAMPS-1:0] l;
    logic [LAMPS-1:0] r;
    logic             b;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard.
  int m_mode = 0;
  int m_phase = 0;
  int m_count = 0;

  function automatic int fill(input int ph);
    return ((1 << ph) - 1) & ((1 << LAMPS) - 1);
  endfunction

  task automatic model_edge(input bit r_, l_, rr_, h_, b_, input int td);
    int   all_on;
    int   nm;
    bit   own;
    exp_t e;
    all_on = (1 << LAMPS) - 1;
    if (r_) begin
      m_mode = 0; m_phase = 0; m_count = 0;
      e = '0;
    end else begin
      int lv, rv;
      lv = 0; rv = 0;
      if (m_mode == 3) begin
        if (m_phase != 0) begin lv = all_on; rv = all_on; end
      end else begin
        if (m_mode == 1) lv = fill(m_phase); else if (b_) lv = all_on;
        if (m_mode == 2) rv = fill(m_phase); else if (b_) rv = all_on;
      end
      e.l = LAMPS'(lv);
      e.r = LAMPS'(rv);

      case (m_mode)
        1: own = l_;
        2: own = rr_;
        3: own = h_ || (l_ && rr_);
        default: own = 1'b0;
      endcase
      if (m_mode != 3 && (h_ || (m_mode == 0 && l_ && rr_))) nm = 3;
      else if (m_mode != 0 && !own) nm = 0;
      else if (m_mode == 0) nm = l_ ? 1 : (rr_ ? 2 : 0);
      else nm = m_mode;

      if (nm != m_mode) begin
        m_mode = nm; m_phase = 0; m_count = 0;
      end else if (m_mode != 0) begin
        if (m_count == td) begin
          m_count = 0;
          if (m_mode == 3) m_phase = 1 - m_phase;
          else m_phase = (m_phase == LAMPS) ? 0 : m_phase + 1;
        end else begin
          m_count = (m_count + 1) % (1 << DIV_W);
        end
      end
    end
    e.b = (m_mode != 0);
    sb_q.push_back(e);
  endtask

  // One clock of stimulus: drive on the falling edge, predict the next rising edge.
  task automatic cyc(input bit r_, l_, rr_, h_, b_, input int td, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r_; left_req = l_; right_req = rr_; hazard_req = h_; brake = b_;
      tick_div = DIV_W'(td);
      model_edge(r_, l_, rr_, h_, b_, td);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (left_lamps !== e.l) begin
          n_err++;
          $display("FAIL left_lamps t=%0t got %b expected %b", $time, left_lamps, e.l);
        end
        n_cmp++;
        if (right_lamps !== e.r) begin
          n_err++;
          $display("FAIL right_lamps t=%0t got %b expected %b", $time, right_lamps, e.r);
        end
        n_cmp++;
        if (busy !== e.b) begin
          n_err++;
          $display("FAIL busy t=%0t got %b expected %b", $time, busy, e.b);
        end
      end
    end
  end

  initial begin : stim
    bit l, r, h, b, rs;
    int td;
    rst = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    tick_div = '0;

    // reset and idle
    cyc(1, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 4);
    // left sweep, tick_div=1
    cyc(0, 1, 0, 0, 0, 1, 20);
    cyc(0, 0, 0, 0, 0, 1, 2);
    // simultaneous left+right -> hazard, then drop right
    cyc(0, 1, 1, 0, 0, 0, 8);
    cyc(0, 1, 0, 0, 0, 0, 10);
    cyc(0, 0, 0, 0, 0, 1, 2);
    // right to 011, then hazard, then drop hazard with right held
    cyc(0, 0, 1, 0, 0, 1, 7);
    cyc(0, 0, 1, 1, 0, 1, 8);
    cyc(0, 0, 1, 0, 0, 1, 10);
    cyc(0, 0, 0, 0, 0, 1, 2);
    // brake overlay: turning, idle, hazard
    cyc(0, 1, 0, 0, 1, 1, 12);
    cyc(0, 0, 0, 0, 1, 1, 4);
    cyc(0, 0, 0, 1, 1, 1, 8);
    cyc(0, 0, 0, 0, 0, 1, 2);
    // reset pulse mid-sequence with left held
    cyc(0, 1, 0, 0, 0, 1, 7);
    cyc(1, 1, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1, 10);
    // prescaler reload lowered below the running count
    cyc(0, 0, 1, 0, 0, 9, 8);
    cyc(0, 0, 1, 0, 0, 2, 30);

    l = 0; r = 0; h = 0; b = 0; rs = 0; td = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) l = ~l;
      if ($urandom_range(15) == 0) r = ~r;
      if ($urandom_range(31) == 0) h = ~h;
      if ($urandom_range(7) == 0) b = ~b;
      if ($urandom_range(39) == 0) td = $urandom_range(15);
      else if ($urandom_range(9) == 0) td = $urandom_range(3);
      rs = ($urandom_range(199) == 0);
      cyc(rs, l, r, h, b, td, 1);
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
